// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: word/bool aliases, fetch FSM states and
// the {instr, pc} entry handed to the decoder.
package fetch_stage_pkg;
  typedef logic [31:0] Word;
  typedef logic        Bool;

  localparam Bool TRUE        = 1'b1;
  localparam Bool FALSE       = 1'b0;
  localparam int  INSTR_BYTES = 4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } FetchState;

  typedef struct packed {
    Word instr;
    Word pc;
  } fetch_entry_t;

  function automatic Word align_word(input Word a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_stage_sync_fifo.sv
// Small synchronous FIFO with flush; head is presented combinationally from
// storage. A push into a full FIFO is accepted only when a pop happens the same cycle.
module fetch_stage_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             full, empty, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited word reads, buffers
// in-order responses and hands {instr, pc} to the decoder; supports redirect and halt.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter Word RESET_PC = 32'h0000_0000,
  parameter int  DEPTH    = 2
) (
  input  logic clk,
  input  logic reset,
  output logic imem_req_valid,
  input  logic imem_req_ready,
  output Word  imem_req_addr,
  input  logic imem_resp_valid,
  input  Word  imem_resp_data,
  output logic out_valid,
  input  logic out_ready,
  output Word  out_instr,
  output Word  out_pc,
  input  logic redirect_valid,
  input  Word  redirect_pc,
  input  logic halt,
  output Bool  halted
);
  localparam int         CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  FetchState    state, state_nxt;
  Word          fetch_pc;
  logic [CW-1:0] inflight, drop, count, pcq_count;
  logic          can_issue, accept, resp, resp_keep, pop_out;
  fetch_entry_t  head, push_entry;
  Word           pcq_head;

  // Buffered words plus outstanding reads never exceed DEPTH, so a response
  // always finds room in the entry FIFO.
  assign can_issue  = ({1'b0, inflight} + {1'b0, count}) < CREDITS;
  assign accept     = imem_req_valid && imem_req_ready;
  assign resp       = imem_resp_valid && !reset;
  assign resp_keep  = resp && (drop == '0) && !redirect_valid;
  assign out_valid  = !reset && (count != '0);
  assign pop_out    = out_valid && out_ready;
  assign push_entry = '{instr: imem_resp_data, pc: pcq_head};

  assign imem_req_addr = fetch_pc;
  assign out_instr     = head.instr;
  assign out_pc        = head.pc;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid)             state_nxt = RUN;
    else if (state == RUN && halt)  state_nxt = HALTED;
  end

  always_comb begin
    imem_req_valid = 1'b0;
    halted         = FALSE;
    if (!reset) begin
      imem_req_valid = (state == RUN) && !redirect_valid && can_issue;
      halted         = ((state == HALTED) && (count == '0) && (inflight == '0)) ? TRUE : FALSE;
    end
  end

  // Responses to reads issued before a redirect are still counted in
  // inflight; drop tells how many of the next ones to discard.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= align_word(redirect_pc);
      inflight <= inflight - CW'(resp);
      drop     <= inflight - CW'(resp);
    end else begin
      if (accept) fetch_pc <= fetch_pc + Word'(INSTR_BYTES);
      inflight <= inflight + CW'(accept) - CW'(resp);
      if (resp && drop != '0) drop <= drop - CW'(1);
    end
  end

  fetch_stage_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop_out),
    .head      (head),
    .count     (count)
  );

  fetch_stage_sync_fifo #(.WIDTH($bits(Word)), .DEPTH(DEPTH)) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (resp_keep),
    .head      (pcq_head),
    .count     (pcq_count)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));
  a_inflight_bound: assert property (@(posedge clk) disable iff (reset) inflight <= CW'(DEPTH));
  a_pcq_tracks: assert property (@(posedge clk) disable iff (reset) pcq_count <= inflight);
endmodule
